// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, issues word reads to the
// instruction memory, holds each returned word for decode until it is
// accepted, applies branch redirects and stops fetching at HALT_ADDR.
//
// state  | meaning
// -------+---------------------------------------------------------------
// ISSUE  | read strobe asserted for the word at pc
// WAIT   | counting down the memory latency; capture when the count is 0
// HOLD   | instruction presented to decode, held while stall_flag is high
// HALT   | pc reached HALT_ADDR; no further reads until reset
`timescale 1ns/1ps
module imem_fetch_ctrl #(
    parameter logic [31:0] RESET_PC    = 32'd0,
    parameter logic [31:0] HALT_ADDR   = 32'd100,
    parameter int unsigned MEM_LATENCY = 1,
    parameter int unsigned ADDR_W      = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_flag,
    input  logic              branch_taken,
    input  logic [31:0]       branch_target,
    output logic              imem_rd_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       inp_instn,
    output logic              inst_valid,
    output logic [31:0]       pc_to_branch,
    output logic [31:0]       nextpc,
    output logic              halted,
    output logic              misalign
);

    typedef enum logic [1:0] {
        ST_ISSUE,
        ST_WAIT,
        ST_HOLD,
        ST_HALT
    } state_t;

    // A reset PC that already sits on the halt address never fetches.
    localparam state_t     RESET_STATE = (RESET_PC == HALT_ADDR) ? ST_HALT : ST_ISSUE;
    localparam logic [2:0] WAIT_INIT   = 3'(MEM_LATENCY - 1);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] instn_q, instn_d;
    logic        valid_q, valid_d;
    logic [31:0] pc_br_q, pc_br_d;
    logic [31:0] nextpc_q, nextpc_d;
    logic        misalign_q, misalign_d;

    logic [31:0] pc_plus4;
    logic [31:0] br_pc;

    assign pc_plus4 = pc_q + 32'd4;
    assign br_pc    = {branch_target[31:2], 2'b00};

    // Next-state and datapath updates; a redirect outranks capture and accept.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        cnt_d      = cnt_q;
        instn_d    = instn_q;
        valid_d    = valid_q;
        pc_br_d    = pc_br_q;
        nextpc_d   = nextpc_q;
        misalign_d = misalign_q;

        if (branch_taken && (state_q != ST_HALT)) begin
            // In-flight read data is simply never captured after this.
            pc_d    = br_pc;
            valid_d = 1'b0;
            cnt_d   = 3'd0;
            state_d = (br_pc == HALT_ADDR) ? ST_HALT : ST_ISSUE;
            if (branch_target[1:0] != 2'b00) begin
                misalign_d = 1'b1;
            end
        end else begin
            case (state_q)
                ST_ISSUE: begin
                    state_d = ST_WAIT;
                    cnt_d   = WAIT_INIT;
                end
                ST_WAIT: begin
                    if (cnt_q == 3'd0) begin
                        instn_d  = imem_rdata;
                        pc_br_d  = pc_q;
                        nextpc_d = pc_plus4;
                        valid_d  = 1'b1;
                        state_d  = ST_HOLD;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
                ST_HOLD: begin
                    if (!stall_flag) begin
                        pc_d    = pc_plus4;
                        valid_d = 1'b0;
                        state_d = (pc_plus4 == HALT_ADDR) ? ST_HALT : ST_ISSUE;
                    end
                end
                ST_HALT: begin
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RESET_STATE;
            pc_q       <= RESET_PC;
            cnt_q      <= 3'd0;
            instn_q    <= 32'd0;
            valid_q    <= 1'b0;
            pc_br_q    <= 32'd0;
            nextpc_q   <= 32'd0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            cnt_q      <= cnt_d;
            instn_q    <= instn_d;
            valid_q    <= valid_d;
            pc_br_q    <= pc_br_d;
            nextpc_q   <= nextpc_d;
            misalign_q <= misalign_d;
        end
    end

    // Strobe and halt flag decode from state; held low while reset is asserted.
    assign imem_rd_en   = (state_q == ST_ISSUE) && !reset;
    assign halted       = (state_q == ST_HALT) && !reset;
    assign imem_addr    = pc_q[ADDR_W+1:2];
    assign inp_instn    = instn_q;
    assign inst_valid   = valid_q;
    assign pc_to_branch = pc_br_q;
    assign nextpc       = nextpc_q;
    assign misalign     = misalign_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl: latency-1 and latency-3 instances
// with behavioural memories, plus a halt-at-reset instance. Expected
// presentations are queued as stimulus is applied and popped by monitors.
`timescale 1ns/1ps
module tb_imem_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset1 = 1'b1;
    logic        reset3 = 1'b1;
    logic        stall_flag = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'd0;

    logic        rd_en1, valid1, halted1, mis1;
    logic [9:0]  addr1;
    logic [31:0] rdata1, instn1, pcb1, npc1;
    logic        rd_en2, valid2, halted2, mis2;
    logic [9:0]  addr2;
    logic [31:0] instn2, pcb2, npc2;
    logic        rd_en3, valid3, halted3, mis3;
    logic [9:0]  addr3;
    logic [31:0] rdata3, instn3, pcb3, npc3;

    always #5 clk = ~clk;

    imem_fetch_ctrl #(.RESET_PC(32'd0), .HALT_ADDR(32'd100), .MEM_LATENCY(1), .ADDR_W(10)) u1 (
        .clk(clk), .reset(reset1), .stall_flag(stall_flag), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem_rd_en(rd_en1), .imem_addr(addr1),
        .imem_rdata(rdata1), .inp_instn(instn1), .inst_valid(valid1), .pc_to_branch(pcb1),
        .nextpc(npc1), .halted(halted1), .misalign(mis1));

    imem_fetch_ctrl #(.RESET_PC(32'h10), .HALT_ADDR(32'h10), .MEM_LATENCY(1), .ADDR_W(10)) u2 (
        .clk(clk), .reset(reset1), .stall_flag(stall_flag), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem_rd_en(rd_en2), .imem_addr(addr2),
        .imem_rdata(32'd0), .inp_instn(instn2), .inst_valid(valid2), .pc_to_branch(pcb2),
        .nextpc(npc2), .halted(halted2), .misalign(mis2));

    imem_fetch_ctrl #(.RESET_PC(32'd0), .HALT_ADDR(32'd100), .MEM_LATENCY(3), .ADDR_W(10)) u3 (
        .clk(clk), .reset(reset3), .stall_flag(stall_flag), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem_rd_en(rd_en3), .imem_addr(addr3),
        .imem_rdata(rdata3), .inp_instn(instn3), .inst_valid(valid3), .pc_to_branch(pcb3),
        .nextpc(npc3), .halted(halted3), .misalign(mis3));

    // Behavioural memories: data is driven only in the cycle it is due.
    logic [31:0] mem1 [0:1023];
    logic [31:0] mem3 [0:1023];
    logic        rv1 = 1'b0;
    logic [9:0]  ra1 = 10'd0;
    logic [2:0]  rv3 = 3'd0;
    logic [9:0]  ra3 [3];

    always @(posedge clk) begin
        rv1    <= rd_en1;
        ra1    <= addr1;
        rv3    <= {rv3[1:0], rd_en3};
        ra3[0] <= addr3;
        ra3[1] <= ra3[0];
        ra3[2] <= ra3[1];
    end
    assign rdata1 = rv1 ? mem1[ra1] : 32'hBAD0_0001;
    assign rdata3 = rv3[2] ? mem3[ra3[2]] : 32'hBAD0_0003;

    int n_checks = 0;
    int n_pass   = 0;
    int now      = 0;
    int cyc1     = -1;
    int cyc3     = -1;
    int rd_cnt1  = 0;
    logic pv1 = 1'b0;
    logic pv3 = 1'b0;

    typedef struct {
        logic [31:0] instn;
        logic [31:0] pc;
        int          cyc;
    } exp_t;
    exp_t q1[$];
    exp_t q3[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cmp_exp(input string tag, input exp_t e, input int cyc,
                           input logic [31:0] instn, input logic [31:0] pcb, input logic [31:0] npc);
        if (e.cyc >= 0) check({tag, " cycle"}, cyc, e.cyc);
        check({tag, " inp_instn"}, instn, e.instn);
        check({tag, " pc_to_branch"}, pcb, e.pc);
        check({tag, " nextpc"}, npc, e.pc + 32'd4);
    endtask

    // Scoreboard monitors: a new presentation is a rising edge of inst_valid.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset1) begin
                cyc1 = -1;
                pv1  = 1'b0;
            end else begin
                cyc1++;
                if (rd_en1) rd_cnt1++;
                if (valid1 && !pv1) begin
                    check("u1 presentation_expected", {31'd0, q1.size() != 0}, 32'd1);
                    if (q1.size() != 0) begin
                        e = q1.pop_front();
                        cmp_exp("u1", e, cyc1, instn1, pcb1, npc1);
                    end
                end
                pv1 = valid1;
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset3) begin
                cyc3 = -1;
                pv3  = 1'b0;
            end else begin
                cyc3++;
                if (valid3 && !pv3) begin
                    check("u3 presentation_expected", {31'd0, q3.size() != 0}, 32'd1);
                    if (q3.size() != 0) begin
                        e = q3.pop_front();
                        cmp_exp("u3", e, cyc3, instn3, pcb3, npc3);
                    end
                end
                pv3 = valid3;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #1;
        now += n;
    endtask

    task automatic wait_until(input int c);
        adv(c - now);
    endtask

    task automatic release1();
        repeat (1) @(posedge clk);
        #1;
        rd_cnt1 = 0;
        reset1  = 1'b0;
        now     = 0;
    endtask

    task automatic reset_u1();
        reset1       = 1'b1;
        stall_flag   = 1'b0;
        branch_taken = 1'b0;
        @(posedge clk);
        #1;
        release1();
    endtask

    task automatic chk_reset(input string tag);
        check({tag, " inp_instn"}, instn1, 32'd0);
        check({tag, " inst_valid"}, {31'd0, valid1}, 32'd0);
        check({tag, " pc_to_branch"}, pcb1, 32'd0);
        check({tag, " nextpc"}, npc1, 32'd0);
        check({tag, " imem_rd_en"}, {31'd0, rd_en1}, 32'd0);
        check({tag, " halted"}, {31'd0, halted1}, 32'd0);
        check({tag, " misalign"}, {31'd0, mis1}, 32'd0);
    endtask

    task automatic push1(input int w, input logic [31:0] pc, input int cyc);
        q1.push_back('{mem1[w], pc, cyc});
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem1[i] = 32'hA000_0000 + 32'(i);
            mem3[i] = 32'hC000_0000 + 32'(i);
        end

        // T1: reset values, then three unstalled fetches
        reset1 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset("t1 reset");
        check("u2 halted during reset", {31'd0, halted2}, 32'd0);
        release1();
        push1(0, 32'd0, 2);
        push1(1, 32'd4, 5);
        push1(2, 32'd8, 8);
        @(negedge clk);
        check("t1 c0 rd_en", {31'd0, rd_en1}, 32'd1);
        check("t1 c0 addr", {22'd0, addr1}, 32'd0);
        check("t1 c0 valid", {31'd0, valid1}, 32'd0);
        check("u2 halted after reset", {31'd0, halted2}, 32'd1);
        check("u2 rd_en after reset", {31'd0, rd_en2}, 32'd0);
        adv(1);
        @(negedge clk);
        check("t1 c1 rd_en", {31'd0, rd_en1}, 32'd0);
        check("t1 c1 valid", {31'd0, valid1}, 32'd0);
        wait_until(9);
        check("t1 reads issued", rd_cnt1, 32'd3);
        check("t1 queue drained", q1.size(), 32'd0);

        // T2: stall while B is held
        reset_u1();
        push1(0, 32'd0, 2);
        push1(1, 32'd4, 5);
        push1(2, 32'd8, 13);
        wait_until(5);
        stall_flag = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t2 held valid", {31'd0, valid1}, 32'd1);
            check("t2 held instn", instn1, mem1[1]);
            check("t2 held pc", pcb1, 32'd4);
            check("t2 no read", {31'd0, rd_en1}, 32'd0);
            adv(1);
        end
        stall_flag = 1'b0;
        wait_until(14);
        check("t2 queue drained", q1.size(), 32'd0);

        // T3: branch during the capture cycle of the fetch at pc=8
        reset_u1();
        push1(0, 32'd0, 2);
        push1(1, 32'd4, 5);
        push1(16, 32'h40, 10);
        wait_until(7);
        branch_taken  = 1'b1;
        branch_target = 32'h40;
        adv(1);
        branch_taken = 1'b0;
        @(negedge clk);
        check("t3 redirect rd_en", {31'd0, rd_en1}, 32'd1);
        check("t3 redirect addr", {22'd0, addr1}, 32'd16);
        check("t3 capture suppressed", {31'd0, valid1}, 32'd0);
        check("t3 misalign clear", {31'd0, mis1}, 32'd0);
        wait_until(11);
        check("t3 queue drained", q1.size(), 32'd0);

        // T4: sequential run to the halt address
        reset_u1();
        for (int k = 0; k < 25; k++) push1(k, 32'(4 * k), 2 + 3 * k);
        wait_until(74);
        @(negedge clk);
        check("t4 last held pc", pcb1, 32'd96);
        check("t4 not yet halted", {31'd0, halted1}, 32'd0);
        adv(1);
        @(negedge clk);
        check("t4 halted", {31'd0, halted1}, 32'd1);
        check("t4 halt rd_en", {31'd0, rd_en1}, 32'd0);
        check("t4 halt valid", {31'd0, valid1}, 32'd0);
        adv(1);
        branch_taken  = 1'b1;
        branch_target = 32'h3;
        adv(1);
        branch_taken = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4 stays halted", {31'd0, halted1}, 32'd1);
            check("t4 no read after halt", {31'd0, rd_en1}, 32'd0);
            check("t4 no valid after halt", {31'd0, valid1}, 32'd0);
            adv(1);
        end
        check("t4 branch ignored misalign", {31'd0, mis1}, 32'd0);
        check("t4 reads issued", rd_cnt1, 32'd25);
        check("t4 queue drained", q1.size(), 32'd0);

        // T5: misaligned branch while stalled in HOLD, then reset mid-WAIT
        reset_u1();
        push1(0, 32'd0, 2);
        push1(8, 32'h20, 5);
        wait_until(2);
        stall_flag    = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 32'h23;
        adv(1);
        stall_flag   = 1'b0;
        branch_taken = 1'b0;
        @(negedge clk);
        check("t5 misalign", {31'd0, mis1}, 32'd1);
        check("t5 rd_en", {31'd0, rd_en1}, 32'd1);
        check("t5 aligned addr", {22'd0, addr1}, 32'd8);
        check("t5 held flushed", {31'd0, valid1}, 32'd0);
        wait_until(7);
        reset1 = 1'b1;
        adv(1);
        @(negedge clk);
        chk_reset("t5 reset");
        check("t5 queue drained", q1.size(), 32'd0);

        // T6: three-cycle memory latency
        adv(1);
        reset3 = 1'b0;
        now    = 0;
        q3.push_back('{mem3[0], 32'd0, 4});
        q3.push_back('{mem3[1], 32'd4, 9});
        q3.push_back('{mem3[2], 32'd8, 14});
        @(negedge clk);
        check("t6 c0 rd_en", {31'd0, rd_en3}, 32'd1);
        wait_until(3);
        @(negedge clk);
        check("t6 c3 not yet valid", {31'd0, valid3}, 32'd0);
        wait_until(5);
        @(negedge clk);
        check("t6 c5 rd_en", {31'd0, rd_en3}, 32'd1);
        check("t6 c5 addr", {22'd0, addr3}, 32'd1);
        wait_until(16);
        check("t6 queue drained", q3.size(), 32'd0);
        reset3 = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
